// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: widths, reset PC, PC step and FSM encoding.
package instr_fetch_unit_pkg;

    localparam int ADDR_W = 16;
    localparam int INST_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
    localparam int PC_STEP = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry valid/ready holding register with load, flush and drain.
// Flush wins over load; a drain (valid & ready) empties the entry unless reloaded.
module fetch_out_buf #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              flush,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] pc
);

    // Entry state: flush clears, load fills, a completed transfer drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (flush) begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one outstanding req/ack read at a
// time, and hands fetched words to the IR stage via a one-entry output buffer.
// Redirects reload the PC and squash any in-flight or buffered instruction.
module instr_fetch_unit #(
    parameter int                ADDR_W   = instr_fetch_unit_pkg::ADDR_W,
    parameter int                INST_W   = instr_fetch_unit_pkg::INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = instr_fetch_unit_pkg::RESET_PC,
    parameter int                PC_STEP  = instr_fetch_unit_pkg::PC_STEP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    import instr_fetch_unit_pkg::*;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic              buf_free;
    logic              buf_load;

    // The buffer can take a new word if it is empty or draining at this edge.
    assign buf_free = !inst_valid || inst_ready;
    // Only an unsquashed ack in REQ delivers an instruction.
    assign buf_load = (state == REQ) && mem_ack && !redirect_valid;

    // Fetch FSM: request issue, handshake hold, and redirect squashing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (fetch_en && buf_free) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                    end
                end
                REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            // The handshake cannot be aborted; wait out the ack.
                            state <= DISCARD;
                        end
                    end else if (mem_ack) begin
                        pc      <= pc + STEP;
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                DISCARD: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    fetch_out_buf #(
        .DATA_W (INST_W),
        .ADDR_W (ADDR_W)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .load_data (mem_rdata),
        .load_pc   (mem_addr),
        .flush     (redirect_valid),
        .ready     (inst_ready),
        .valid     (inst_valid),
        .data      (inst_out),
        .pc        (inst_pc)
    );

endmodule
